// File: rtl/adc_dma_framer.sv
// rtl/adc_dma_framer.sv - frames a continuous ADC readout stream into header/payload/XOR-tail DMA packets
module adc_dma_framer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [15:0]       frame_seq,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, WAIT_LAST} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  word_cnt;
  logic [DATA_W-1:0] csum;
  logic [DATA_W-1:0] header;
  logic              out_free;
  logic              out_hs;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = (state == PAYLOAD) && out_free;
  assign busy          = (state != IDLE);

  always_comb begin
    header       = '0;
    header[31:0] = {8'hA5, 8'h00, frame_seq};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_seq     <= '0;
      len           <= '0;
      word_cnt      <= '0;
      csum          <= '0;
    end else begin
      // A completed handshake frees the register; a load below in the same cycle overrides this.
      if (out_hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Only start when a payload word is already waiting, so no empty frames are emitted.
          if (enable && s_axis_tvalid && out_free) begin
            m_axis_tdata  <= header;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            len           <= (frame_len == '0) ? LEN_W'(1) : frame_len;
            word_cnt      <= '0;
            csum          <= '0;
            state         <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (s_axis_tvalid && s_axis_tready) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            csum          <= csum ^ s_axis_tdata;
            word_cnt      <= word_cnt + LEN_W'(1);
            if (word_cnt + LEN_W'(1) == len) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (out_free) begin
            m_axis_tdata  <= csum;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b1;
            state         <= WAIT_LAST;
          end
        end
        WAIT_LAST: begin
          if (out_hs && m_axis_tlast) begin
            frame_seq <= frame_seq + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_dma_framer.sv
// tb/tb_adc_dma_framer.sv - directed bench with a frame-level reference model for adc_dma_framer
module tb_adc_dma_framer;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [LEN_W-1:0]  frame_len;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic [15:0]       frame_seq;
  logic              busy;

  always #5 clk = ~clk;

  adc_dma_framer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_len(frame_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_seq(frame_seq), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {tlast, tdata} expected on each output handshake
  logic [31:0] src_q[$];   // words the source still has to offer
  logic [31:0] plan_q[$];  // payload words staged for the next modelled frame
  logic [31:0] obs_q[$];   // every word the DMA side accepted
  bit          s_hs = 1'b0;
  bit          rand_mode = 1'b0;
  bit          prev_hold = 1'b0;
  logic [32:0] prev_word = '0;
  int          acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Frame model: header carries the sequence number, max(fl,1) payload words, tail is their XOR.
  task automatic push_frame(input logic [15:0] seq, input int fl);
    int n;
    logic [31:0] x;
    n = (fl == 0) ? 1 : fl;
    x = '0;
    exp_q.push_back({1'b0, 8'hA5, 8'h00, seq});
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = plan_q.pop_front();
      x = x ^ w;
      src_q.push_back(w);
      exp_q.push_back({1'b0, w});
    end
    exp_q.push_back({1'b1, x});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b expected pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic wait_accepted(input int target, input string name);
    int i;
    for (i = 0; i < 3000 && acc_cnt < target; i++) begin
      @(negedge clk);
      #2;
    end
    checks++;
    if (acc_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: got accepted=%0d expected %0d", name, acc_cnt, target);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
  endtask

  // Source and sink drivers: inputs change just after the active edge.
  always @(posedge clk) begin
    #1;
    if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
    s_axis_tvalid = (src_q.size() > 0);
    s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
    m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
      s_hs      = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
      end
      if (!busy) check("idle_tready", 64'(s_axis_tready), 64'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back(m_axis_tdata);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h expected no output", m_axis_tdata);
        end else begin
          check("out_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
        end
      end
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_word = {m_axis_tlast, m_axis_tdata};
      s_hs      = s_axis_tvalid && s_axis_tready;
      if (s_hs) acc_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b0;
    enable = 1'b0;
    frame_len = '0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_seq", 64'(frame_seq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;

    // Basic frame
    frame_len = 16'd4;
    for (int i = 1; i <= 4; i++) plan_q.push_back(32'(i));
    push_frame(16'd0, 4);
    enable = 1'b1;
    drain("basic");
    check("basic_seq", 64'(frame_seq), 64'd1);
    check("basic_count", 64'(obs_q.size()), 64'd6);
    check("basic_header", 64'(obs_at(0)), 64'hA500_0000);
    check("basic_tail", 64'(obs_at(5)), 64'h0000_0004);

    // Back-to-back frames
    pulse_reset();
    frame_len = 16'd2;
    for (int f = 0; f < 2; f++) begin
      plan_q.push_back(32'hAAAA_0000);
      plan_q.push_back(32'h0000_BBBB);
      push_frame(16'(f), 2);
    end
    drain("b2b");
    check("b2b_seq", 64'(frame_seq), 64'd2);
    check("b2b_tail1", 64'(obs_at(3)), 64'hAAAA_BBBB);
    check("b2b_header2", 64'(obs_at(4)), 64'hA500_0001);
    check("b2b_tail2", 64'(obs_at(7)), 64'hAAAA_BBBB);

    // Random backpressure
    obs_q.delete();
    rand_mode = 1'b1;
    frame_len = 16'd16;
    for (int i = 0; i < 16; i++) plan_q.push_back(32'(i));
    push_frame(16'd2, 16);
    drain("random");
    rand_mode = 1'b0;
    check("random_seq", 64'(frame_seq), 64'd3);
    check("random_count", 64'(obs_q.size()), 64'd18);
    check("random_tail", 64'(obs_at(17)), 64'd0);

    // Zero length
    obs_q.delete();
    frame_len = 16'd0;
    plan_q.push_back(32'h1234_5678);
    push_frame(16'd3, 0);
    drain("zero");
    check("zero_seq", 64'(frame_seq), 64'd4);
    check("zero_count", 64'(obs_q.size()), 64'd3);
    check("zero_payload", 64'(obs_at(1)), 64'h1234_5678);
    check("zero_tail", 64'(obs_at(2)), 64'h1234_5678);

    // Enable drop and length change mid-frame; one spare word must stay unconsumed
    obs_q.delete();
    frame_len = 16'd8;
    for (int i = 0; i < 9; i++) plan_q.push_back(32'h100 + 32'(i));
    push_frame(16'd4, 8);
    src_q.push_back(plan_q.pop_front());
    base = acc_cnt;
    wait_accepted(base + 3, "enable_drop");
    enable = 1'b0;
    frame_len = 16'd2;
    drain("enable_drop");
    repeat (5) @(negedge clk);
    #2;
    check("drop_count", 64'(obs_q.size()), 64'd10);
    check("drop_busy", 64'(busy), 64'd0);
    check("drop_tready", 64'(s_axis_tready), 64'd0);
    check("drop_spare", 64'(src_q.size()), 64'd1);
    check("drop_seq", 64'(frame_seq), 64'd5);
    src_q.delete();
    repeat (2) @(negedge clk);

    // Reset mid-frame
    frame_len = 16'd4;
    for (int i = 0; i < 4; i++) plan_q.push_back(32'hC0 + 32'(i));
    push_frame(16'd5, 4);
    enable = 1'b1;
    base = acc_cnt;
    wait_accepted(base + 2, "reset_mid");
    rst = 1'b0;
    #1;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_tlast", 64'(m_axis_tlast), 64'd0);
    check("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    check("midrst_tready", 64'(s_axis_tready), 64'd0);
    check("midrst_seq", 64'(frame_seq), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    src_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
    frame_len = 16'd1;
    plan_q.push_back(32'h0000_0055);
    push_frame(16'd0, 1);
    drain("after_reset");
    check("after_header", 64'(obs_at(0)), 64'hA500_0000);
    check("after_seq", 64'(frame_seq), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_dma_framer.md
# adc_dma_framer

Downstream of the ADC driver, between its PS-width readout stream and the PS DMA. The block splits the continuous ADC readout into framed DMA packets. Each frame is a header word, `frame_len` payload words and a tail word carrying an XOR checksum. `m_axis_tlast` is asserted on the tail word so the DMA closes one buffer per frame. Backpressure from the DMA passes straight through to the ADC driver; no words are dropped.

## Interface
- `DATA_W`, default 32: stream width. Must equal `ps_axis_width` and be ≥32.
- `LEN_W`, default 16: width of `frame_len`.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: permits a new frame to start. Sampled only in IDLE.
- `frame_len` in LEN_W: payload words per frame. Latched when the header is loaded. 0 is treated as 1.
- `s_axis_tdata` in DATA_W: payload word from the ADC driver.
- `s_axis_tvalid` in 1: payload word valid.
- `s_axis_tready` out 1: block accepts a payload word.
- `m_axis_tdata` out DATA_W: framed word to the DMA.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tready` in 1: DMA accepts the output word.
- `m_axis_tlast` out 1: asserted with the tail word only.
- `frame_seq` out 16: count of completed frames.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Output register (`m_axis_tdata`/`tvalid`/`tlast`) is loadable when `out_free = !m_axis_tvalid || m_axis_tready`.
- State IDLE:
  - Transition when `enable && s_axis_tvalid && out_free`.
  - Load header: bits[31:24]=8'hA5, [23:16]=8'h00, [15:0]=`frame_seq`, upper bits zero.
  - Latch `len = max(frame_len,1)`, clear `word_cnt` and `csum`, go to PAYLOAD.
  - The payload word is not consumed this cycle.
- State PAYLOAD:
  - `s_axis_tready = out_free`.
  - On each `s_axis_tvalid && s_axis_tready`: load the word to output with tlast=0, `csum ^= word`, `word_cnt++`.
  - When the accepted word is number `len`, go to TAIL.
- State TAIL:
  - `s_axis_tready=0`.
  - When `out_free`: load `csum` with tlast=1 and go to WAIT_LAST.
- State WAIT_LAST:
  - `s_axis_tready=0`.
  - On tail handshake (`m_axis_tvalid && m_axis_tready && m_axis_tlast`): `frame_seq++` (wraps FFFF→0000), go to IDLE.
- `s_axis_tready` is 0 in IDLE, TAIL and WAIT_LAST.
- `enable` deasserted mid-frame: the frame completes normally, and no new frame starts until `enable` is reasserted.
- `frame_len` changes mid-frame are ignored until the next header.
- An output word, once valid, holds data, valid and last stable until its handshake.
- No empty frames: a header is emitted only when a payload word is already waiting.
- Reset (async, any state):
  - state=IDLE; `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `s_axis_tready=0`.
  - `frame_seq=0`, `busy=0`, `word_cnt=0`, `csum=0`.
  - A partial frame is discarded; the DMA side is recovered by software.

## Timing
- Header becomes valid on the edge after the IDLE start condition is met.
- Payload latency: a word accepted at edge k is valid on `m_axis` after edge k.
- Tail valid: the edge after the last payload is loaded, provided `out_free`.
- With `m_axis_tready=1` throughout and the source always valid:
  - a frame occupies `len+2` output cycles plus 1 cycle in WAIT_LAST/IDLE;
  - payload throughput is 1 word/cycle.
- `busy` rises on the edge that loads the header. It falls on the edge of the tail handshake.
- `frame_seq` updates on the same edge as the tail handshake.
- Simultaneous output handshake and new load in one cycle is legal, with no bubble, in PAYLOAD and TAIL.

## Test plan
- **Basic frame.** `enable=1`, `frame_len=4`, payload 1,2,3,4, `m_axis_tready=1`. Expected output: 0xA5000000, 1, 2, 3, 4, 0x00000004 with tlast on the last word only. `frame_seq` goes 0→1.
- **Back-to-back frames.** Two frames with `frame_len=2`, payload AAAA0000, 0000BBBB. Header 2 is 0xA5000001; each tail is 0xAAAABBBB. `frame_seq=2` at the end.
- **Random backpressure.**
  - Stimulus: `m_axis_tready` 50% random, `frame_len=16`, incrementing payload.
  - Output data is held stable whenever valid && !ready, and the sequence is exact.
  - No payload is lost or duplicated; tail equals the XOR of 0..15, which is 0.
- **Zero length.** `frame_len=0`, payload 0x12345678. Output: header, 0x12345678, tail 0x12345678 with tlast.
- **Enable drop and length change mid-frame.**
  - `frame_len=8`; after 3 payload words, `enable=0` and `frame_len=2`.
  - The frame still carries 8 payload words plus the tail, then the block stays in IDLE with `s_axis_tready=0`.
- **Reset mid-frame.** Assert `rst=0` after 2 of 4 payload words. Outputs are immediately 0 and `frame_seq=0`. After release, the next frame header is 0xA5000000.
